// File: rtl/fp_mul_iter.sv
// ---------------------------------------------------------------------------
// fp_mul_iter
// Sequential IEEE-754-style floating-point multiplier with configurable
// exponent/fraction widths.  The mantissa product is built by a shift-add
// core that consumes one multiplier bit per cycle, so every operation
// (including special operands) takes exactly MAN_W+4 cycles from the
// accepting clock edge to the done pulse.  Rounding is round-to-nearest-even.
// Subnormal inputs are flushed to zero and subnormal results are flushed to
// signed zero.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous active-high reset, clears all state
//   start       in   1   operation request, sampled in IDLE and DONE only
//   x, y        in   W   operands, captured on an accepted start
//   busy        out  1   operation in flight (through the done cycle)
//   done        out  1   one-cycle pulse, z and flags valid
//   z           out  W   result, held until the next operation's done
//   f_invalid   out  1   0*inf or signalling NaN operand
//   f_overflow  out  1   rounded result exceeded largest finite value
//   f_underflw  out  1   nonzero result flushed to zero
//   f_inexact   out  1   result differs from the exact product
// ---------------------------------------------------------------------------
module fp_mul_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] x,
    input  logic [EXP_W+MAN_W:0] y,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] z,
    output logic                 f_invalid,
    output logic                 f_overflow,
    output logic                 f_underflw,
    output logic                 f_inexact
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;          // significand width incl. hidden bit
    localparam int EW = EXP_W + 2;          // signed exponent working width
    localparam int CW = $clog2(N + 1);

    localparam logic signed [EW-1:0] BIAS   = EW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX   = EW'((2 ** EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E = EW'(0);
    localparam logic [CW-1:0]        LAST_STEP = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_MUL    = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [W-1:0]          r_z;
    logic                  r_f_invalid;
    logic                  r_f_overflow;
    logic                  r_f_underflw;
    logic                  r_f_inexact;

    logic [W-1:0]          r_x;
    logic [W-1:0]          r_y;
    logic                  r_sign;
    logic                  r_special;
    logic [W-1:0]          r_spec_z;
    logic                  r_spec_inv;
    logic signed [EW-1:0]  r_exp;
    logic [N-1:0]          r_mcand;
    logic [2*N-1:0]        r_prod;      // {partial sum, remaining multiplier bits}
    logic [CW-1:0]         r_cnt;
    logic [N-1:0]          r_mant;
    logic                  r_guard;
    logic                  r_sticky;

    // Operand field decode
    logic [EXP_W-1:0]      w_ex;
    logic [EXP_W-1:0]      w_ey;
    logic [MAN_W-1:0]      w_fx;
    logic [MAN_W-1:0]      w_fy;
    logic                  w_sign;
    logic                  w_x_zero, w_y_zero;
    logic                  w_x_inf,  w_y_inf;
    logic                  w_x_nan,  w_y_nan;
    logic                  w_x_snan, w_y_snan;
    logic signed [EW-1:0]  w_exp_sum;

    assign w_ex   = r_x[W-2:MAN_W];
    assign w_ey   = r_y[W-2:MAN_W];
    assign w_fx   = r_x[MAN_W-1:0];
    assign w_fy   = r_y[MAN_W-1:0];
    assign w_sign = r_x[W-1] ^ r_y[W-1];

    // Exponent field zero means zero: any fraction there is a subnormal and is flushed.
    assign w_x_zero = (w_ex == {EXP_W{1'b0}});
    assign w_y_zero = (w_ey == {EXP_W{1'b0}});
    assign w_x_inf  = (w_ex == {EXP_W{1'b1}}) && (w_fx == {MAN_W{1'b0}});
    assign w_y_inf  = (w_ey == {EXP_W{1'b1}}) && (w_fy == {MAN_W{1'b0}});
    assign w_x_nan  = (w_ex == {EXP_W{1'b1}}) && (w_fx != {MAN_W{1'b0}});
    assign w_y_nan  = (w_ey == {EXP_W{1'b1}}) && (w_fy != {MAN_W{1'b0}});
    assign w_x_snan = w_x_nan && !w_fx[MAN_W-1];
    assign w_y_snan = w_y_nan && !w_fy[MAN_W-1];

    assign w_exp_sum = $signed({2'b00, w_ex}) + $signed({2'b00, w_ey}) - BIAS;

    logic                  w_spec;
    logic [W-1:0]          w_spec_z;
    logic                  w_spec_inv;
    logic                  w_zero_inf;

    assign w_zero_inf = (w_x_zero && w_y_inf) || (w_x_inf && w_y_zero);

    // Special-operand resolution in priority order: NaN/0*inf, infinity, zero.
    always_comb begin
        w_spec     = 1'b0;
        w_spec_z   = {W{1'b0}};
        w_spec_inv = 1'b0;
        if (w_x_nan || w_y_nan || w_zero_inf) begin
            w_spec     = 1'b1;
            w_spec_z   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_spec_inv = w_zero_inf || w_x_snan || w_y_snan;
        end else if (w_x_inf || w_y_inf) begin
            w_spec   = 1'b1;
            w_spec_z = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_x_zero || w_y_zero) begin
            w_spec   = 1'b1;
            w_spec_z = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_spec   = 1'b0;
        end
    end

    // One shift-add step: add the multiplicand if the current multiplier LSB is set.
    logic [N:0]            w_sum;
    assign w_sum = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_mcand} : {(N+1){1'b0}});

    // Normalisation: the product lies in [1,4); shift so the leading one is at the MSB.
    logic [2*N-1:0]        w_pn;
    assign w_pn = r_prod[2*N-1] ? r_prod : {r_prod[2*N-2:0], 1'b0};

    // Rounding to nearest, ties to even, with carry-out renormalisation.
    logic                  w_inc;
    logic [N:0]            w_mr;
    logic [MAN_W-1:0]      w_frac;
    logic signed [EW-1:0]  w_exp_r;
    logic                  w_ovf;
    logic                  w_unf;

    assign w_inc   = r_guard && (r_sticky || r_mant[0]);
    assign w_mr    = {1'b0, r_mant} + {{N{1'b0}}, w_inc};
    assign w_frac  = w_mr[N] ? w_mr[MAN_W:1] : w_mr[MAN_W-1:0];
    assign w_exp_r = r_exp + (w_mr[N] ? ONE_E : ZERO_E);
    assign w_ovf   = (w_exp_r >= EMAX);
    assign w_unf   = (w_exp_r <= ZERO_E);

    logic [W-1:0]          w_res_z;
    logic [3:0]            w_res_f;      // {invalid, overflow, underflow, inexact}

    // Final result selection: specials first, then overflow/underflow, then normal.
    always_comb begin
        w_res_z = {W{1'b0}};
        w_res_f = 4'b0000;
        if (r_special) begin
            w_res_z = r_spec_z;
            w_res_f = {r_spec_inv, 3'b000};
        end else if (w_ovf) begin
            w_res_z = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_res_f = 4'b0101;
        end else if (w_unf) begin
            w_res_z = {r_sign, {(W-1){1'b0}}};
            w_res_f = 4'b0011;
        end else begin
            w_res_z = {r_sign, w_exp_r[EXP_W-1:0], w_frac};
            w_res_f = {3'b000, r_guard | r_sticky};
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_z          <= {W{1'b0}};
            r_f_invalid  <= 1'b0;
            r_f_overflow <= 1'b0;
            r_f_underflw <= 1'b0;
            r_f_inexact  <= 1'b0;
            r_x          <= {W{1'b0}};
            r_y          <= {W{1'b0}};
            r_sign       <= 1'b0;
            r_special    <= 1'b0;
            r_spec_z     <= {W{1'b0}};
            r_spec_inv   <= 1'b0;
            r_exp        <= ZERO_E;
            r_mcand      <= {N{1'b0}};
            r_prod       <= {(2*N){1'b0}};
            r_cnt        <= {CW{1'b0}};
            r_mant       <= {N{1'b0}};
            r_guard      <= 1'b0;
            r_sticky     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_busy  <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sign     <= w_sign;
                    r_special  <= w_spec;
                    r_spec_z   <= w_spec_z;
                    r_spec_inv <= w_spec_inv;
                    r_exp      <= w_exp_sum;
                    r_mcand    <= {1'b1, w_fx};
                    r_prod     <= {{N{1'b0}}, 1'b1, w_fy};
                    r_cnt      <= {CW{1'b0}};
                    r_state    <= S_MUL;
                end
                S_MUL: begin
                    r_prod <= {w_sum, r_prod[N-1:1]};
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_mant   <= w_pn[2*N-1:N];
                    r_guard  <= w_pn[N-1];
                    r_sticky <= |w_pn[N-2:0];
                    if (r_prod[2*N-1]) begin
                        r_exp <= r_exp + ONE_E;
                    end
                    r_state  <= S_ROUND;
                end
                S_ROUND: begin
                    r_z          <= w_res_z;
                    r_f_invalid  <= w_res_f[3];
                    r_f_overflow <= w_res_f[2];
                    r_f_underflw <= w_res_f[1];
                    r_f_inexact  <= w_res_f[0];
                    r_done       <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    // A start in the done cycle is accepted; busy stays high.
                    if (start) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_state <= S_UNPACK;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign z          = r_z;
    assign f_invalid  = r_f_invalid;
    assign f_overflow = r_f_overflow;
    assign f_underflw = r_f_underflw;
    assign f_inexact  = r_f_inexact;

endmodule

// File: tb/tb_fp_mul_iter.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_iter
// Self-checking bench for fp_mul_iter: an fp32 instance and an fp16
// instance.  Directed cases cover arithmetic, specials, rounding, latency,
// handshake and reset; random fp32 pairs are compared against a reference
// that multiplies exactly in double precision and rounds the exact product.
// ---------------------------------------------------------------------------
module tb_fp_mul_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0;
    logic [31:0] x32 = 32'd0;
    logic [31:0] y32 = 32'd0;
    logic        busy32, done32;
    logic [31:0] z32;
    logic        fi32, fo32, fu32, fx32;

    logic        start16 = 1'b0;
    logic [15:0] x16 = 16'd0;
    logic [15:0] y16 = 16'd0;
    logic        busy16, done16;
    logic [15:0] z16;
    logic        fi16, fo16, fu16, fx16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_iter #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .x(x32), .y(y32),
        .busy(busy32), .done(done32), .z(z32),
        .f_invalid(fi32), .f_overflow(fo32), .f_underflw(fu32), .f_inexact(fx32)
    );

    fp_mul_iter #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .x(x16), .y(y16),
        .busy(busy16), .done(done16), .z(z16),
        .f_invalid(fi16), .f_overflow(fo16), .f_underflw(fu16), .f_inexact(fx16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact product in double precision, then RNE to fp32 with FTZ.
    function automatic logic [35:0] ref32(input logic [31:0] a, input logic [31:0] b);
        logic        s, az, bz, ai, bi, an, bn, asn, bsn, g, st;
        logic [63:0] da, db, dp;
        logic [23:0] km;
        real         ra, rb, rp;
        int          ue, e32;
        s   = a[31] ^ b[31];
        az  = (a[30:23] == 8'h00);
        bz  = (b[30:23] == 8'h00);
        ai  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        an  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        asn = an && !a[22];
        bsn = bn && !b[22];
        if (an || bn || (az && bi) || (ai && bz))
            return {32'h7FC00000, (az && bi) || (ai && bz) || asn || bsn, 3'b000};
        if (ai || bi) return {s, 8'hFF, 23'd0, 4'b0000};
        if (az || bz) return {s, 31'd0, 4'b0000};
        da = {1'b0, 11'(int'(a[30:23]) + 896), a[22:0], 29'd0};
        db = {1'b0, 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
        ra = $bitstoreal(da);
        rb = $bitstoreal(db);
        rp = ra * rb;
        dp = $realtobits(rp);
        ue = int'(dp[62:52]) - 1023;
        g  = dp[28];
        st = |dp[27:0];
        km = {1'b0, dp[51:29]} + {23'd0, g & (st | dp[29])};
        if (km[23]) ue = ue + 1;
        e32 = ue + 127;
        if (e32 >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
        if (e32 <= 0)   return {s, 31'd0, 4'b0011};
        return {s, 8'(e32), km[22:0], 3'b000, g | st};
    endfunction

    function automatic logic [31:0] rand_fp();
        int unsigned sel;
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        sel = $urandom_range(0, 31);
        f   = 23'($urandom);
        s   = 1'($urandom);
        if (sel == 0)      e = 8'h00;
        else if (sel == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = 23'd0;
        end
        else if (sel < 5)  e = 8'($urandom_range(0, 255));
        else               e = 8'($urandom_range(70, 185));
        return {s, e, f};
    endfunction

    // Drive a start for one clock; returns at the negedge after the accepting edge.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b);
        x32 = a; y32 = b; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic wait32(output int lat, output logic busy_ok);
        lat = 0; busy_ok = 1'b1;
        while (done32 !== 1'b1 && lat < 60) begin
            busy_ok = busy_ok & busy32;
            @(posedge clk); lat++; @(negedge clk);
        end
        busy_ok = busy_ok & busy32;
    endtask

    task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ez, input logic [3:0] ef);
        int lat; logic bok;
        @(negedge clk);
        issue32(a, b);
        wait32(lat, bok);
        chk({tag, "/lat"}, 32'(lat), 32'd27);
        chk({tag, "/busy"}, 32'(bok), 32'd1);
        chk({tag, "/z"}, z32, ez);
        chk({tag, "/flags"}, 32'({fi32, fo32, fu32, fx32}), 32'(ef));
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ez, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        x16 = a; y16 = b; start16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        while (done16 !== 1'b1 && lat < 60) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        chk({tag, "/lat"}, 32'(lat), 32'd14);
        chk({tag, "/z"}, 32'(z16), 32'(ez));
        chk({tag, "/flags"}, 32'({fi16, fo16, fu16, fx16}), 32'(ef));
    endtask

    initial begin
        int lat, lat2, ndone;
        logic bok;
        logic [35:0] r;
        logic [31:0] a, b;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst/busy", 32'(busy32), 32'd0);
        chk("rst/done", 32'(done32), 32'd0);
        chk("rst/z", z32, 32'd0);
        chk("rst/flags", 32'({fi32, fo32, fu32, fx32}), 32'd0);
        reset = 1'b0;

        // Basic arithmetic and done pulse width
        op32("mul1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        @(negedge clk);
        chk("post/done", 32'(done32), 32'd0);
        chk("post/busy", 32'(busy32), 32'd0);

        // Specials
        op32("zero_inf", 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        op32("ninf_x2", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        op32("snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        op32("qnan_zero", 32'hFFC00000, 32'h00000000, 32'h7FC00000, 4'b0000);
        op32("negzero", 32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000);
        op32("subn_inf", 32'h00000001, 32'h7F800000, 32'h7FC00000, 4'b1000);

        // Overflow / underflow boundaries
        op32("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        op32("unf", 32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);

        // Rounding
        op32("rne_up", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        op32("rne_dn", 32'h3F800001, 32'h3F7FFFFF, 32'h3F800000, 4'b0001);

        // Start during MUL is ignored and does not queue
        @(negedge clk);
        issue32(32'h3FC00000, 32'h40000000);
        repeat (5) @(negedge clk);
        x32 = 32'h40800000; y32 = 32'h40800000; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wait32(lat, bok);
        chk("ign/lat", 32'(lat + 6), 32'd27);
        chk("ign/z", z32, 32'h40400000);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 === 1'b1) ndone++;
        end
        chk("ign/nodone", 32'(ndone), 32'd0);
        chk("ign/idle", 32'(busy32), 32'd0);

        // Back-to-back: start accepted in the done cycle
        @(negedge clk);
        issue32(32'h40000000, 32'h40400000);
        wait32(lat, bok);
        chk("b2b1/z", z32, 32'h40C00000);
        issue32(32'h40400000, 32'h40400000);
        wait32(lat2, bok);
        chk("b2b2/lat", 32'(lat2), 32'd27);
        chk("b2b2/busy", 32'(bok), 32'd1);
        chk("b2b2/z", z32, 32'h41100000);

        // Reset in the middle of an operation
        @(negedge clk);
        issue32(32'h3FC00000, 32'h3FC00000);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst/z", z32, 32'd0);
        chk("midrst/busy", 32'(busy32), 32'd0);
        chk("midrst/done", 32'(done32), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 === 1'b1) ndone++;
        end
        chk("midrst/nodone", 32'(ndone), 32'd0);
        chk("midrst/zhold", z32, 32'd0);

        // fp16 instance
        op16("h_one", 16'h3C00, 16'h3C00, 16'h3C00, 4'b0000);
        op16("h_2x3", 16'h4000, 16'h4200, 16'h4600, 4'b0000);
        op16("h_inf0", 16'h7C00, 16'h0000, 16'h7E00, 4'b1000);

        // Random fp32 pairs against the reference model
        for (int i = 0; i < 1000; i++) begin
            a = rand_fp();
            b = rand_fp();
            r = ref32(a, b);
            op32($sformatf("rnd%0d_%h_%h", i, a, b), a, b, r[35:4], r[3:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
